fetch_stage: RTL and testbench

Instruction-fetch front end that sits directly upstream of the decoder.
- Owns the program counter and drives the synchronous instruction memory (one-cycle read latency).
- Buffers returned instructions in a small skid FIFO so decode can stall without losing fetched words.
- Takes branch redirects from the function stage, flushing everything fetched down the wrong path.
- Presents a valid-qualified instruction with its PC to the decode register.

---
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives a one-cycle-latency
// synchronous instruction memory, buffers returned words in a small skid FIFO
// and presents a valid-qualified instruction with its PC to decode.
// Branch redirects flush the FIFO and drop any response still in flight.
module fetch_stage #(
  parameter int                  PC_WIDTH   = 32,
  parameter int                  INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [PC_WIDTH-1:0]   imem_addr,
  output logic                  imem_req,
  input  logic [INST_WIDTH-1:0] imem_data,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_target,
  input  logic                  stall,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   inst_pc
);

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [PC_WIDTH-1:0]   pc;
  } entry_t;

  // Count spans 0..DEPTH; occupancy adds the in-flight request on top of that.
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = CW + 1;

  logic [PC_WIDTH-1:0] pc_q;
  logic                infl_q;
  logic [PC_WIDTH-1:0] infl_pc_q;

  // Entry 0 is always the head; later entries shift down on a pop.
  entry_t              fifo_q [DEPTH];
  logic [CW-1:0]       count_q;

  logic                pop;
  logic                push;
  logic [OW-1:0]       occupancy;
  logic [AW-1:0]       push_idx;

  // Handshake decode: consume, capture and issue decisions for this cycle.
  // NOTE: every output of this block is assigned unconditionally at the top,
  // so no path through it can leave a value unassigned and infer a latch.
  always_comb begin
    inst_valid = (count_q != '0);
    pop        = inst_valid & ~stall;
    push       = infl_q & ~redirect;
    // A request issued now lands in the FIFO next cycle, so it is only safe
    // if the slots already promised (buffered + in flight - leaving) leave room.
    occupancy  = OW'(count_q) + OW'(infl_q) - OW'(pop);
    imem_req   = ~rst & ~redirect & (occupancy < OW'(DEPTH));
    // After a simultaneous pop the tail moves down by one slot.
    push_idx   = AW'(count_q - CW'(pop));
  end

  assign imem_addr = pc_q;
  assign inst      = fifo_q[0].inst;
  assign inst_pc   = fifo_q[0].pc;

  // Program counter and the single outstanding memory request.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
    end else if (redirect) begin
      pc_q      <= redirect_target;
      infl_q    <= 1'b0;
    end else if (imem_req) begin
      pc_q      <= pc_q + PC_WIDTH'(1);
      infl_q    <= 1'b1;
      infl_pc_q <= pc_q;
    end else begin
      infl_q    <= 1'b0;
    end
  end

  // Skid FIFO: shift on pop, append the returning word at the tail.
  // NOTE: the storage is reset because the head entry drives inst/inst_pc
  // directly and those outputs must read as zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (redirect) begin
      // Entries are left in place so the outputs simply hold while invalid.
      count_q <= '0;
    end else begin
      // Popping the last entry leaves the head untouched, so inst/inst_pc
      // keep their last value while the FIFO is empty.
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (i + 1 < int'(count_q)) begin
            fifo_q[i] <= fifo_q[i + 1];
          end
        end
      end
      if (push) begin
        fifo_q[push_idx] <= '{inst: imem_data, pc: infl_pc_q};
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a queue-based model of the fetch
// pipeline predicts the outputs every cycle, directed sequences pin the model
// with literal expectations, then a randomized phase exercises stall,
// redirect and reset mixes.
module tb_fetch_stage;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFFE;
  localparam logic [31:0] TAG    = 32'hA000_0000;
  localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .PC_WIDTH  (32),
    .INST_WIDTH(32),
    .RESET_PC  (RST_PC),
    .DEPTH     (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_req       (imem_req),
    .imem_data      (imem_data),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .stall          (stall),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  // Synchronous instruction memory: contents are TAG + address; a cycle with
  // no request returns junk so a spurious capture is visible.
  always @(posedge clk) begin
    imem_data <= imem_req ? (TAG + imem_addr) : JUNK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the fetched-but-unconsumed PCs live in a queue, plus at
  // most one PC waiting on memory. Checked and advanced on every falling edge.
  // ---------------------------------------------------------------------------
  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_infl_pc;
  bit          m_infl;
  bit          m_live = 1'b0;
  bit          m_pop;
  bit          m_req;

  always @(negedge clk) begin
    if (rst) begin
      check("req_during_rst", imem_req, 0);
      m_q.delete();
      m_pc   = RST_PC;
      m_infl = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      m_pop = (m_q.size() != 0) && !stall;
      m_req = !redirect && (m_q.size() + int'(m_infl) - int'(m_pop) < DEPTH);
      check("model_req", imem_req, m_req);
      check("model_addr", imem_addr, m_pc);
      check("model_valid", inst_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        check("model_inst_pc", inst_pc, m_q[0]);
        check("model_inst", inst, TAG + m_q[0]);
      end
      if (redirect) begin
        m_q.delete();
        m_infl = 1'b0;
        m_pc   = redirect_target;
      end else begin
        if (m_pop) void'(m_q.pop_front());
        if (m_infl) m_q.push_back(m_infl_pc);
        if (m_req) begin
          m_infl_pc = m_pc;
          m_pc      = m_pc + 32'd1;
          m_infl    = 1'b1;
        end else begin
          m_infl = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until a valid instruction with the given PC is presented.
  task automatic wait_pc(input logic [31:0] pc, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = inst_valid && (inst_pc == pc);
    end
    check(name, ok, 1);
  endtask

  // Wait (bounded) for the next valid instruction and check its PC.
  task automatic first_valid_pc(input logic [31:0] pc, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = inst_valid;
    end
    check({name, "_seen"}, ok, 1);
    check(name, inst_pc, pc);
  endtask

  logic [31:0] wrap_seq [4];

  initial begin
    wrap_seq        = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    rst             = 1'b1;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_target = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, RST_PC);

    // Release: first request at C0, first valid two cycles later, PC wraps.
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("c0_req", imem_req, 1);
    check("c0_addr", imem_addr, RST_PC);
    check("c0_valid", inst_valid, 0);
    @(negedge clk);
    check("c1_valid", inst_valid, 0);
    check("c1_addr", imem_addr, 32'hFFFF_FFFF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("seq_valid", inst_valid, 1);
      check("seq_pc", inst_pc, wrap_seq[k]);
      check("seq_inst", inst, TAG + wrap_seq[k]);
    end

    // Stall for 4 cycles while inst_pc = 4, then drain 4,5,6,7 back to back.
    wait_pc(32'd3, "reach_pc3");
    next_cycle();
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_valid", inst_valid, 1);
      check("stall_hold_pc", inst_pc, 32'd4);
      if (k == 3) check("stall_req_off", imem_req, 0);
      if (k < 3) next_cycle();
    end
    next_cycle();
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("drain_valid", inst_valid, 1);
      check("drain_pc", inst_pc, 32'd4 + 32'(k));
    end

    // Redirect to 0x40 in steady state.
    next_cycle();
    redirect        = 1'b1;
    redirect_target = 32'h40;
    @(negedge clk);
    check("redir_t_req", imem_req, 0);
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    check("redir_t1_valid", inst_valid, 0);
    check("redir_t1_addr", imem_addr, 32'h40);
    check("redir_t1_req", imem_req, 1);
    @(negedge clk);
    check("redir_t2_valid", inst_valid, 0);
    @(negedge clk);
    check("redir_t3_valid", inst_valid, 1);
    check("redir_t3_pc", inst_pc, 32'h40);
    @(negedge clk);
    check("redir_t4_pc", inst_pc, 32'h41);

    // Redirect together with stall; stall held over the target's arrival.
    next_cycle();
    redirect        = 1'b1;
    redirect_target = 32'h100;
    stall           = 1'b1;
    next_cycle();
    redirect = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rs_t3_valid", inst_valid, 1);
    check("rs_t3_pc", inst_pc, 32'h100);
    next_cycle();
    @(negedge clk);
    check("rs_t4_pc", inst_pc, 32'h100);
    next_cycle();
    stall = 1'b0;
    @(negedge clk);
    check("rs_t5_pc", inst_pc, 32'h100);
    @(negedge clk);
    check("rs_t6_pc", inst_pc, 32'h101);

    // Back-to-back redirects: the last target wins.
    next_cycle();
    redirect        = 1'b1;
    redirect_target = 32'h200;
    next_cycle();
    redirect_target = 32'h300;
    next_cycle();
    redirect = 1'b0;
    first_valid_pc(32'h300, "b2b_pc");

    // Fill the FIFO under stall, then reset for one cycle.
    next_cycle();
    stall = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("full_valid", inst_valid, 1);
    check("full_req", imem_req, 0);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst   = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    check("post_rst_valid", inst_valid, 0);
    check("post_rst_addr", imem_addr, RST_PC);
    check("post_rst_req", imem_req, 1);
    @(negedge clk);
    check("post_rst_c1_valid", inst_valid, 0);
    @(negedge clk);
    check("post_rst_pc0", inst_pc, RST_PC);
    @(negedge clk);
    check("post_rst_pc1", inst_pc, 32'hFFFF_FFFF);

    // Randomized mix; the model checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      stall    = ($urandom_range(0, 99) < 30);
      redirect = ($urandom_range(0, 99) < 6);
      case ($urandom_range(0, 3))
        0:       redirect_target = $urandom;
        1:       redirect_target = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        2:       redirect_target = 32'($urandom_range(0, 15));
        default: redirect_target = $urandom;
      endcase
      rst = ($urandom_range(0, 999) < 4);
    end
    next_cycle();
    stall    = 1'b0;
    redirect = 1'b0;
    rst      = 1'b0;
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
